// File: rtl/counter128_snapshot_serializer.sv
// Captures a snapshot of a wide free-running counter on a trigger pulse and
// streams it out as CHUNK_WIDTH beats over a valid/ready handshake.
//
// Ports:
//   clk           - clock, all state updates on posedge
//   resetb        - asynchronous active-low reset
//   count_in      - counter value from upstream (DATA_WIDTH)
//   trigger       - capture request, sampled on posedge clk
//   dout          - current chunk of the shadow register (CHUNK_WIDTH)
//   dout_valid    - dout holds a valid beat
//   dout_ready    - sink accepts the beat
//   dout_last     - current beat is the final chunk
//   busy          - a transfer is in progress
//   overrun       - sticky flag: a trigger was dropped during a transfer
//   clear_overrun - synchronous clear of overrun (a same-cycle drop wins)
//
// CHUNK_WIDTH must divide DATA_WIDTH exactly.
module counter128_snapshot_serializer #(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned CHUNK_WIDTH = 8,
    parameter bit          MSB_FIRST   = 1'b0
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic [DATA_WIDTH-1:0]  count_in,
    input  logic                   trigger,
    output logic [CHUNK_WIDTH-1:0] dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   dout_last,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   clear_overrun
);

    localparam int unsigned NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [DATA_WIDTH-1:0]   shadow_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    overrun_q;

    logic                    xfer;
    logic                    last_xfer;
    logic                    capture;
    logic                    drop;
    logic [IDX_W-1:0]        sel;
    int unsigned             sel_base;

    // Handshake and trigger qualification
    always_comb begin
        xfer      = (state_q == ST_SHIFT) && dout_ready;
        last_xfer = xfer && (idx_q == LAST_IDX);
        // A trigger coinciding with the final beat starts the next snapshot
        // immediately instead of being counted as lost.
        capture   = trigger && ((state_q == ST_IDLE) || last_xfer);
        drop      = trigger && (state_q == ST_SHIFT) && !last_xfer;
    end

    // State register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_xfer && !trigger) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow register, beat index and sticky overrun flag
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            shadow_q  <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (capture) begin
                shadow_q <= count_in;
                idx_q    <= '0;
            end else if (xfer) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end

            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // Output decode from registered state; dout is a pure chunk select
    always_comb begin
        dout_valid = 1'b0;
        busy       = 1'b0;
        dout_last  = 1'b0;
        sel        = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
        sel_base   = 32'(sel) * CHUNK_WIDTH;
        dout       = shadow_q[sel_base +: CHUNK_WIDTH];
        overrun    = overrun_q;
        if (state_q == ST_SHIFT) begin
            dout_valid = 1'b1;
            busy       = 1'b1;
            dout_last  = (idx_q == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_counter128_snapshot_serializer.sv
// Bench for counter128_snapshot_serializer: one LSB-first and one MSB-first
// instance share all inputs and are checked each cycle against a beat-queue
// model, plus directed literal checks.
module tb_counter128_snapshot_serializer;

    localparam logic [127:0] V1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    logic         clk;
    logic         resetb;
    logic [127:0] count_in;
    logic         trigger;
    logic         dout_ready;
    logic         clear_overrun;

    logic [7:0]   l_dout, m_dout;
    logic         l_valid, m_valid, l_last, m_last, l_busy, m_busy, l_ovr, m_ovr;

    counter128_snapshot_serializer #(.DATA_WIDTH(128), .CHUNK_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .resetb(resetb), .count_in(count_in), .trigger(trigger),
        .dout(l_dout), .dout_valid(l_valid), .dout_ready(dout_ready), .dout_last(l_last),
        .busy(l_busy), .overrun(l_ovr), .clear_overrun(clear_overrun)
    );

    counter128_snapshot_serializer #(.DATA_WIDTH(128), .CHUNK_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .resetb(resetb), .count_in(count_in), .trigger(trigger),
        .dout(m_dout), .dout_valid(m_valid), .dout_ready(dout_ready), .dout_last(m_last),
        .busy(m_busy), .overrun(m_ovr), .clear_overrun(clear_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pending capture is simply the list of beats still to be sent.
    logic [7:0] q_lsb[$];
    logic [7:0] q_msb[$];
    logic       m_overrun;

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            q_lsb.delete();
            q_msb.delete();
            m_overrun = 1'b0;
        end else begin
            logic busy_now, xfer, accept;
            logic [127:0] v;
            busy_now = (q_lsb.size() != 0);
            xfer     = busy_now && dout_ready;
            accept   = trigger && (!busy_now || (xfer && q_lsb.size() == 1));
            if (clear_overrun) m_overrun = 1'b0;
            if (trigger && !accept) m_overrun = 1'b1;
            if (xfer) begin
                void'(q_lsb.pop_front());
                void'(q_msb.pop_front());
            end
            if (accept) begin
                v = count_in;
                for (int k = 0; k < 16; k++) begin
                    q_lsb.push_back(v[k*8 +: 8]);
                    q_msb.push_back(v[(15-k)*8 +: 8]);
                end
            end
        end
    end

    // Per-cycle comparison against the model
    logic       cmp_en = 1'b0;
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;

    always @(negedge clk) begin
        if (cmp_en) begin
            logic ev;
            ev = (q_lsb.size() != 0);
            check("lsb_valid", 128'(l_valid), 128'(ev));
            check("msb_valid", 128'(m_valid), 128'(ev));
            check("lsb_busy", 128'(l_busy), 128'(ev));
            check("msb_busy", 128'(m_busy), 128'(ev));
            check("lsb_overrun", 128'(l_ovr), 128'(m_overrun));
            check("msb_overrun", 128'(m_ovr), 128'(m_overrun));
            if (ev) begin
                check("lsb_dout", 128'(l_dout), 128'(q_lsb[0]));
                check("msb_dout", 128'(m_dout), 128'(q_msb[0]));
                check("lsb_last", 128'(l_last), 128'(q_lsb.size() == 1));
                check("msb_last", 128'(m_last), 128'(q_msb.size() == 1));
            end else begin
                check("lsb_last_idle", 128'(l_last), 128'(0));
            end
            if (resetb && prev_v && !prev_r) begin
                check("stall_hold_valid", 128'(l_valid), 128'(1));
                check("stall_hold_dout", 128'(l_dout), 128'(prev_d));
            end
            prev_v = l_valid;
            prev_r = dout_ready;
            prev_d = l_dout;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_capture(input logic [127:0] v);
        count_in = v;
        trigger  = 1'b1;
        step();
        trigger  = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (l_busy && c < 100) begin
            step();
            c++;
        end
        @(negedge clk);
        check("drain_idle", 128'(l_busy), 128'(0));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc;
        logic [7:0] last_beat;

        resetb        = 1'b0;
        count_in      = '0;
        trigger       = 1'b0;
        dout_ready    = 1'b1;
        clear_overrun = 1'b0;

        // Reset then idle
        @(posedge clk);
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 resetb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_valid", 128'(l_valid), 128'(0));
            check("idle_busy", 128'(l_busy), 128'(0));
            check("idle_overrun", 128'(l_ovr), 128'(0));
            check("idle_dout", 128'(l_dout), 128'(0));
            check("idle_dout_msb", 128'(m_dout), 128'(0));
        end
        step();

        // Basic capture, ready held high
        start_capture(V1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("basic_beat", 128'(l_dout), 128'(i));
            check("basic_last", 128'(l_last), 128'(i == 15));
            check("msb_beat", 128'(m_dout), 128'(15 - i));
            check("msb_last_lit", 128'(m_last), 128'(i == 15));
            step();
        end
        @(negedge clk);
        check("basic_busy_fall", 128'(l_busy), 128'(0));
        step();

        // Backpressure with ready pattern 1,0,0,...
        start_capture(V1);
        n = 0;
        cyc = 0;
        last_beat = 8'h00;
        while (n < 16 && cyc < 200) begin
            dout_ready = (cyc % 3 == 0);
            @(negedge clk);
            if (l_valid && dout_ready) begin
                check("bp_beat", 128'(l_dout), 128'(n));
                last_beat = l_dout;
                n++;
            end
            step();
            cyc++;
        end
        dout_ready = 1'b1;
        check("bp_transfers", 128'(n), 128'(16));
        check("bp_last_beat", 128'(last_beat), 128'(8'h0F));
        drain();

        // Trigger during a transfer is dropped and sets overrun
        start_capture(V1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("ovr_beat", 128'(l_dout), 128'(i));
            step();
            if (i == 5) begin
                count_in = 128'hDEAD_BEEF;
                trigger  = 1'b1;
            end else begin
                trigger  = 1'b0;
            end
            if (i == 7) check("ovr_set", 128'(l_ovr), 128'(1));
        end
        trigger = 1'b0;
        @(negedge clk);
        check("ovr_sticky", 128'(l_ovr), 128'(1));
        step();
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        @(negedge clk);
        check("ovr_cleared", 128'(l_ovr), 128'(0));
        step();

        // Drop and clear in the same cycle: set wins
        start_capture(V1);
        step();
        trigger       = 1'b1;
        clear_overrun = 1'b1;
        step();
        trigger       = 1'b0;
        clear_overrun = 1'b0;
        @(negedge clk);
        check("set_wins", 128'(l_ovr), 128'(1));
        drain();
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;

        // Back-to-back capture on the final transfer
        start_capture(V1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("b2b_first_beat", 128'(l_dout), 128'(i));
            if (i == 15) begin
                count_in = 128'h1;
                trigger  = 1'b1;
            end
            step();
        end
        trigger = 1'b0;
        @(negedge clk);
        check("b2b_valid", 128'(l_valid), 128'(1));
        check("b2b_dout", 128'(l_dout), 128'(8'h01));
        check("b2b_msb_dout", 128'(m_dout), 128'(8'h00));
        check("b2b_no_overrun", 128'(l_ovr), 128'(0));
        drain();

        // Asynchronous reset in the middle of a transfer
        start_capture(V1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_pre_beat", 128'(l_dout), 128'(i));
            if (i < 7) step();
        end
        #1 resetb = 1'b0;
        #1;
        check("async_valid", 128'(l_valid), 128'(0));
        check("async_busy", 128'(l_busy), 128'(0));
        check("async_msb_valid", 128'(m_valid), 128'(0));
        check("async_dout", 128'(l_dout), 128'(0));
        check("async_last", 128'(l_last), 128'(0));
        step();
        step();
        resetb = 1'b1;
        step();
        @(negedge clk);
        check("post_rst_idle", 128'(l_valid), 128'(0));
        step();
        start_capture({128{1'b1}});
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("ones_beat", 128'(l_dout), 128'(8'hFF));
            check("ones_msb_beat", 128'(m_dout), 128'(8'hFF));
            check("ones_last", 128'(l_last), 128'(i == 15));
            step();
        end
        @(negedge clk);
        check("ones_done", 128'(l_busy), 128'(0));
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
